wave_fetch: RTL and testbench
=============================

# wave_fetch

Byte-wide read front-end between the sample player and the SDRAM controller, in the `clk_vid` domain. Turns the player's byte requests into 16-bit word reads with a line cache of two words: the current word plus the next word, which is prefetched. Keeps the player off the SDRAM during ROM/WAV download and bounds every miss with a timeout so playback can never stall.

## Interface
Parameters:
- `ADDR_W`, 25: byte address width, matching the ioctl address.
- `TIMEOUT`, 63: maximum cycles to wait for `mem_ready` before a miss is abandoned (6-bit counter).

Ports:
- `clk_sys` in 1: block clock; the top level ties it to `clk_vid`.
- `reset` in 1: synchronous, active-high.
- `dl_active` in 1: download in progress; SDRAM is owned by the loader.
- `req` in 1: one-cycle byte read request.
- `req_addr` in ADDR_W: byte address, sampled when `req`=1.
- `ack` out 1: one-cycle pulse; `rdata` is valid in the same cycle.
- `rdata` out 8: returned byte; holds its value until the next `ack`.
- `mem_rd` out 1: one-cycle SDRAM read strobe.
- `mem_addr` out ADDR_W: word address with bit 0 forced to 0; stable from `mem_rd` until `mem_ready` or timeout.
- `mem_ready` in 1: one-cycle pulse; `mem_dout` is valid.
- `mem_dout` in 16: `[7:0]` is the even byte, `[15:8]` is the odd byte.
- `err_timeout` out 1: sticky; set by any timeout.
- `err_proto` out 1: sticky; set by `req` while busy.

## Operation
- Two cache lines: A (current) and B (prefetched next word). Each line has a tag `addr[ADDR_W-1:1]`, a valid bit and 16 bits of data.
- States: IDLE, FETCH, WAIT, PREFETCH, PWAIT.

IDLE:
- On `req`, a hit on A or B returns the byte selected by `req_addr[0]` with `ack` on the next cycle.
- A hit on B promotes B to A, invalidates B, and enters PREFETCH for tag+1.
- A miss enters FETCH.
- With no `req`, A valid and B invalid, the block enters PREFETCH.

FETCH:
- Drives `mem_rd`=1 for one cycle with the missed word address, then goes to WAIT.

WAIT:
- On `mem_ready`: fill A, invalidate B, `ack` next cycle with the selected byte, then go to PREFETCH.
- If the counter reaches TIMEOUT first: `ack` with `rdata`=8'h00, set `err_timeout`, invalidate A and B, go to IDLE.

PREFETCH / PWAIT:
- Same read as FETCH/WAIT, but the fill goes to B and there is no `ack`.
- A `req` arriving in PREFETCH or PWAIT is held in a one-deep pending register and does not set `err_proto`.
- When the prefetch completes (`mem_ready` or timeout), the pending request is serviced as if newly issued in IDLE. A prefetch timeout only invalidates B and sets `err_timeout`.

Protocol error:
- `req` in FETCH or WAIT, or a second `req` while one is pending, is dropped and sets `err_proto`.

Download (`dl_active`=1):
- Both lines are invalidated every cycle.
- No `mem_rd` is issued.
- Any `req` gets `ack` next cycle with 8'h00.
- An outstanding WAIT/PWAIT is abandoned (state goes to IDLE, any later `mem_ready` is ignored). An abandoned WAIT still produces its `ack` (8'h00) so the requester never hangs.

Wrap-around:
- Prefetch tag+1 wraps modulo 2^(ADDR_W-1); no special case.

Reset:
- `ack`=0, `rdata`=8'h00, `mem_rd`=0, `mem_addr`=0, both errors 0.
- Lines invalid, pending cleared, state IDLE.
- Reset asserted in mid-WAIT discards that transaction and issues no `ack`.

## Timing
- Hit: `req` at cycle N, `ack` at N+1.
- Miss: `req` at N, `mem_rd` at N+1, `mem_ready` at M, `ack` at M+1.
- Timeout counter:
  - Cleared on `mem_rd`, incremented each WAIT/PWAIT cycle.
  - A timeout fires when the count equals TIMEOUT; `ack` (WAIT) follows on the next cycle.
- `mem_ready` arriving in the same cycle as the timeout threshold counts as success.
- `mem_ready` received in IDLE is ignored.
- `dl_active` takes precedence over `req` and `mem_ready` arriving in the same cycle.
- At most one SDRAM read is outstanding at any time.

## Structure
- The shared sound package holds:
  - the state enum `wf_state_t`;
  - the constant `WF_SILENCE` = 8'h00;
  - the line type `wf_line_t`: {valid, tag, data}.
- One sub-module, `wave_line_cache`: the two-line store with hit compare, promote and invalidate. The FSM and timeout counter stay in `wave_fetch`.

## Test plan
- Cold read: `req` 0x100, `mem_ready` 3 cycles after `mem_rd` with 16'hBEEF.
  - `ack` carries 8'hEF.
  - A prefetch `mem_rd` follows for 0x102.
- Sequential read:
  - `req` 0x101 returns 8'hBE at N+1 with no `mem_rd`.
  - `req` 0x102 after the prefetch fill hits B in 1 cycle and triggers a prefetch of 0x104.
- Request during prefetch:
  - `req` 0x200 in PWAIT is held; it is serviced after the prefetch `mem_ready`.
  - `ack` carries the correct byte and `err_proto` stays 0.
- Timeout: `mem_ready` withheld.
  - `ack` with 8'h00 exactly TIMEOUT+1 cycles after `mem_rd`.
  - `err_timeout`=1; a late `mem_ready` is ignored.
- Download: `dl_active`=1 mid-WAIT.
  - `ack` 8'h00; no further `mem_rd` while `dl_active` is high.
  - After release, a `req` to the old address misses.
- Protocol and reset:
  - Second `req` in WAIT: `err_proto`=1 and exactly one `ack`.
  - `reset` mid-WAIT: no `ack`, all outputs at reset values.

Source files
------------

// File: rtl/wave_fetch_pkg.sv
// Shared sound-path types for the wave sample fetch front-end.
package wave_fetch_pkg;

    localparam int WF_ADDR_W = 25;
    localparam int WF_TAG_W  = WF_ADDR_W - 1;

    localparam logic [7:0] WF_SILENCE = 8'h00;

    typedef enum logic [2:0] {
        WF_IDLE,
        WF_FETCH,
        WF_WAIT,
        WF_PREFETCH,
        WF_PWAIT
    } wf_state_t;

    typedef struct packed {
        logic                valid;
        logic [WF_TAG_W-1:0] tag;
        logic [15:0]         data;
    } wf_line_t;

    // Even byte lives in [7:0], odd byte in [15:8].
    function automatic logic [7:0] wf_pick_byte(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/wave_line_cache.sv
// Two-line word store: line A holds the current word, line B the prefetched next word.
module wave_line_cache
    import wave_fetch_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [WF_TAG_W-1:0] lookup_tag,
    output logic                hit_a,
    output logic                hit_b,
    output logic [15:0]         data_a,
    output logic [15:0]         data_b,
    output logic                a_valid,
    output logic                b_valid,
    output logic [WF_TAG_W-1:0] a_tag,
    output logic [WF_TAG_W-1:0] b_tag,
    input  logic                fill_a,
    input  logic                fill_b,
    input  logic [WF_TAG_W-1:0] fill_tag,
    input  logic [15:0]         fill_data,
    input  logic                promote,
    input  logic                inv_b,
    input  logic                inv_all
);

    wf_line_t line_a;
    wf_line_t line_b;

    assign hit_a   = line_a.valid && (line_a.tag == lookup_tag);
    assign hit_b   = line_b.valid && (line_b.tag == lookup_tag);
    assign data_a  = line_a.data;
    assign data_b  = line_b.data;
    assign a_valid = line_a.valid;
    assign b_valid = line_b.valid;
    assign a_tag   = line_a.tag;
    assign b_tag   = line_b.tag;

    // Line updates; a bulk invalidate wins over any fill or promote in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset || inv_all) begin
            line_a <= '0;
            line_b <= '0;
        end else if (fill_a) begin
            line_a       <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
            line_b.valid <= 1'b0;
        end else if (fill_b) begin
            line_b <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        end else if (promote) begin
            line_a       <= line_b;
            line_b.valid <= 1'b0;
        end else if (inv_b) begin
            line_b.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wave_fetch.sv
// Byte read front-end for the sample player: byte requests in, 16-bit SDRAM word reads out.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// WF_IDLE     | waiting for a request (or a held one); may start a prefetch
// WF_FETCH    | demand read strobe on the bus
// WF_WAIT     | waiting for demand data; requester is owed an ack
// WF_PREFETCH | next-word read strobe on the bus
// WF_PWAIT    | waiting for prefetch data; one request may be held
module wave_fetch
    import wave_fetch_pkg::*;
#(
    parameter int ADDR_W  = WF_ADDR_W,
    parameter int TIMEOUT = 63
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              ack,
    output logic [7:0]        rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    output logic              err_timeout,
    output logic              err_proto
);

    localparam logic [5:0]          TMO     = 6'(TIMEOUT);
    localparam logic [WF_TAG_W-1:0] TAG_ONE = WF_TAG_W'(1);

    wf_state_t           state;
    logic [5:0]          cnt;
    logic                pend_valid;
    logic [ADDR_W-1:0]   pend_addr;
    logic                cur_odd;

    logic [ADDR_W-1:0]   lk_addr;
    logic                take_req;
    logic                in_wait;
    logic                got_data;
    logic                timed_out;
    logic                fill_a;
    logic                fill_b;
    logic                promote;
    logic                inv_b;
    logic                inv_all;

    logic                hit_a;
    logic                hit_b;
    logic [15:0]         data_a;
    logic [15:0]         data_b;
    logic                a_valid;
    logic                b_valid;
    logic [WF_TAG_W-1:0] a_tag;
    logic [WF_TAG_W-1:0] b_tag;

    // Cache-side decisions shared between the line store and the FSM.
    always_comb begin
        lk_addr   = pend_valid ? pend_addr : req_addr;
        take_req  = (state == WF_IDLE) && !dl_active && (req || pend_valid);
        in_wait   = (state == WF_WAIT) || (state == WF_PWAIT);
        got_data  = in_wait && !dl_active && mem_ready;
        timed_out = in_wait && !dl_active && !mem_ready && (cnt == TMO);
        fill_a    = got_data && (state == WF_WAIT);
        fill_b    = got_data && (state == WF_PWAIT);
        promote   = take_req && !hit_a && hit_b;
        inv_b     = timed_out && (state == WF_PWAIT);
        inv_all   = dl_active || (timed_out && (state == WF_WAIT));
    end

    wave_line_cache u_cache (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .lookup_tag(lk_addr[ADDR_W-1:1]),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_tag     (a_tag),
        .b_tag     (b_tag),
        .fill_a    (fill_a),
        .fill_b    (fill_b),
        .fill_tag  (mem_addr[ADDR_W-1:1]),
        .fill_data (mem_dout),
        .promote   (promote),
        .inv_b     (inv_b),
        .inv_all   (inv_all)
    );

    // Sequencer: download override first, then per-state request/read/timeout handling.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= WF_IDLE;
            cnt         <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            cur_odd     <= 1'b0;
            ack         <= 1'b0;
            rdata       <= WF_SILENCE;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            ack    <= 1'b0;
            mem_rd <= 1'b0;
            if (dl_active) begin
                // Anyone waiting gets silence so the player never hangs on a download.
                state      <= WF_IDLE;
                pend_valid <= 1'b0;
                if (req || pend_valid || (state == WF_FETCH) || (state == WF_WAIT)) begin
                    ack   <= 1'b1;
                    rdata <= WF_SILENCE;
                end
            end else begin
                case (state)
                    WF_IDLE: begin
                        if (take_req) begin
                            pend_valid <= 1'b0;
                            cur_odd    <= lk_addr[0];
                            if (req && pend_valid) begin
                                err_proto <= 1'b1;
                            end
                            if (hit_a) begin
                                ack   <= 1'b1;
                                rdata <= wf_pick_byte(data_a, lk_addr[0]);
                            end else if (hit_b) begin
                                ack      <= 1'b1;
                                rdata    <= wf_pick_byte(data_b, lk_addr[0]);
                                mem_rd   <= 1'b1;
                                mem_addr <= {b_tag + TAG_ONE, 1'b0};
                                cnt      <= '0;
                                state    <= WF_PREFETCH;
                            end else begin
                                mem_rd   <= 1'b1;
                                mem_addr <= {lk_addr[ADDR_W-1:1], 1'b0};
                                cnt      <= '0;
                                state    <= WF_FETCH;
                            end
                        end else if (a_valid && !b_valid) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= {a_tag + TAG_ONE, 1'b0};
                            cnt      <= '0;
                            state    <= WF_PREFETCH;
                        end
                    end
                    WF_FETCH: begin
                        if (req) begin
                            err_proto <= 1'b1;
                        end
                        cnt   <= cnt + 6'd1;
                        state <= WF_WAIT;
                    end
                    WF_WAIT: begin
                        if (req) begin
                            err_proto <= 1'b1;
                        end
                        if (mem_ready) begin
                            ack      <= 1'b1;
                            rdata    <= wf_pick_byte(mem_dout, cur_odd);
                            mem_rd   <= 1'b1;
                            mem_addr <= {mem_addr[ADDR_W-1:1] + TAG_ONE, 1'b0};
                            cnt      <= '0;
                            state    <= WF_PREFETCH;
                        end else if (cnt == TMO) begin
                            ack         <= 1'b1;
                            rdata       <= WF_SILENCE;
                            err_timeout <= 1'b1;
                            state       <= WF_IDLE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    WF_PREFETCH, WF_PWAIT: begin
                        if (req) begin
                            if (pend_valid) begin
                                err_proto <= 1'b1;
                            end else begin
                                pend_valid <= 1'b1;
                                pend_addr  <= req_addr;
                            end
                        end
                        if (state == WF_PREFETCH) begin
                            cnt   <= cnt + 6'd1;
                            state <= WF_PWAIT;
                        end else if (mem_ready) begin
                            state <= WF_IDLE;
                        end else if (cnt == TMO) begin
                            err_timeout <= 1'b1;
                            state       <= WF_IDLE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    default: state <= WF_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_fetch.sv
// Directed bench for wave_fetch: expected acks and SDRAM reads are queued with their
// cycle numbers; monitors on the falling edge pop and compare whenever the DUT presents them.
module tb_wave_fetch;

    localparam int TO = 63;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        req;
    logic [24:0] req_addr;
    logic        ack;
    logic [7:0]  rdata;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_dout;
    logic        err_timeout;
    logic        err_proto;

    typedef struct { logic [7:0]  d; int c; } ack_t;
    typedef struct { logic [24:0] a; int c; } rd_t;

    ack_t ack_q[$];
    rd_t  rd_q[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    wave_fetch #(.ADDR_W(25), .TIMEOUT(TO)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dl_active  (dl_active),
        .req        (req),
        .req_addr   (req_addr),
        .ack        (ack),
        .rdata      (rdata),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_dout   (mem_dout),
        .err_timeout(err_timeout),
        .err_proto  (err_proto)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_req(input logic [24:0] a);
        req      = 1'b1;
        req_addr = a;
        tick();
        req      = 1'b0;
    endtask

    task automatic do_ready(input logic [15:0] d);
        mem_ready = 1'b1;
        mem_dout  = d;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic exp_ack(input logic [7:0] d, input int c);
        ack_t e;
        e.d = d;
        e.c = c;
        ack_q.push_back(e);
    endtask

    task automatic exp_rd(input logic [24:0] a, input int c);
        rd_t e;
        e.a = a;
        e.c = c;
        rd_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},         32'(ack),         32'h0);
        check({tag, "_rdata"},       32'(rdata),       32'h0);
        check({tag, "_mem_rd"},      32'(mem_rd),      32'h0);
        check({tag, "_mem_addr"},    32'(mem_addr),    32'h0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'h0);
        check({tag, "_err_proto"},   32'(err_proto),   32'h0);
    endtask

    // Ack monitor.
    always @(negedge clk_sys) begin
        if (ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: rdata %0h at cycle %0d, expected no ack", rdata, cyc);
            end else begin
                ack_t e;
                e = ack_q.pop_front();
                check("ack_data", 32'(rdata), 32'(e.d));
                check("ack_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    // SDRAM read monitor.
    always @(negedge clk_sys) begin
        if (mem_rd === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mem_rd: addr %0h at cycle %0d, expected no read", mem_addr, cyc);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                check("mem_rd_addr", 32'(mem_addr), 32'(e.a));
                check("mem_rd_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected $finish", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        reset     = 1'b1;
        dl_active = 1'b0;
        req       = 1'b0;
        req_addr  = '0;
        mem_ready = 1'b0;
        mem_dout  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Cold read, then prefetch of the next word.
        c = cyc;
        exp_rd(25'h100, c + 1);
        exp_ack(8'hEF, c + 5);
        exp_rd(25'h102, c + 5);
        do_req(25'h100);
        go_to(c + 4);
        do_ready(16'hBEEF);
        go_to(c + 7);
        do_ready(16'h3412);
        go_to(c + 9);

        // Sequential: hit on A, hit on B with promote and prefetch, hit on the promoted line.
        c = cyc;
        exp_ack(8'hBE, c + 1);
        do_req(25'h101);
        c = cyc;
        exp_ack(8'h12, c + 1);
        exp_rd(25'h104, c + 1);
        do_req(25'h102);
        go_to(c + 3);
        do_ready(16'h5678);
        go_to(c + 4);
        c = cyc;
        exp_ack(8'h34, c + 1);
        do_req(25'h103);

        // Request during prefetch is held and served afterwards.
        c = cyc;
        exp_ack(8'h78, c + 1);
        exp_rd(25'h106, c + 1);
        exp_rd(25'h200, c + 6);
        exp_ack(8'hFE, c + 9);
        exp_rd(25'h202, c + 9);
        do_req(25'h104);
        tick();
        do_req(25'h200);
        tick();
        do_ready(16'h9ABC);
        go_to(c + 8);
        do_ready(16'hCAFE);
        go_to(c + 11);
        do_ready(16'h0BAD);
        go_to(c + 12);
        check("pend_err_proto", 32'(err_proto), 32'h0);

        // Timeout on a demand miss.
        c = cyc;
        exp_rd(25'h300, c + 1);
        exp_ack(8'h00, c + 1 + TO + 1);
        do_req(25'h300);
        go_to(c + 20);
        check("err_timeout_before", 32'(err_timeout), 32'h0);
        go_to(c + 65);
        check("err_timeout_after", 32'(err_timeout), 32'h1);
        go_to(c + 67);
        do_ready(16'hFFFF);
        go_to(c + 70);
        c = cyc;
        exp_rd(25'h200, c + 1);
        exp_ack(8'h57, c + 5);
        exp_rd(25'h202, c + 5);
        do_req(25'h200);
        go_to(c + 4);
        do_ready(16'h1357);
        go_to(c + 7);
        do_ready(16'h2468);
        go_to(c + 8);

        // Download abandons the wait, silences requests, and flushes the lines.
        c = cyc;
        exp_rd(25'h600, c + 1);
        exp_ack(8'h00, c + 4);
        exp_ack(8'h00, c + 7);
        do_req(25'h600);
        go_to(c + 3);
        dl_active = 1'b1;
        go_to(c + 6);
        do_req(25'h202);
        go_to(c + 8);
        do_ready(16'hAAAA);
        go_to(c + 12);
        dl_active = 1'b0;
        go_to(c + 14);
        c = cyc;
        exp_rd(25'h200, c + 1);
        exp_ack(8'h87, c + 5);
        exp_rd(25'h202, c + 5);
        do_req(25'h201);
        go_to(c + 4);
        do_ready(16'h8765);
        go_to(c + 7);
        do_ready(16'h4321);
        go_to(c + 8);

        // Second request while waiting is dropped and flagged.
        c = cyc;
        exp_rd(25'h700, c + 1);
        exp_ack(8'h11, c + 5);
        exp_rd(25'h702, c + 5);
        do_req(25'h700);
        tick();
        do_req(25'h701);
        go_to(c + 4);
        do_ready(16'h5511);
        check("err_proto_set", 32'(err_proto), 32'h1);
        go_to(c + 7);
        do_ready(16'h6622);
        go_to(c + 8);

        // Reset in the middle of a wait discards the transaction.
        c = cyc;
        exp_rd(25'h800, c + 1);
        do_req(25'h800);
        go_to(c + 3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("midwait_reset");
        go_to(c + 6);
        do_ready(16'h7777);
        go_to(c + 12);

        check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
